// File: rtl/mem_req_scheduler.sv
// Request front end for the multi-bank memory: round-robin write/read arbitration,
// one memory op per cycle, read data returned through a 4-entry credit-checked FIFO.
module mem_req_scheduler #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_valid,
  output logic              o_rd_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_mem_wen,
  output logic              o_mem_ren,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic [ADDR_W-1:0] o_mem_raddr,
  output logic [DATA_W-1:0] o_mem_din,
  input  logic [DATA_W-1:0] i_mem_dout
);

  localparam int unsigned Depth = 4;
  localparam logic GntWrite = 1'b0;
  localparam logic GntRead  = 1'b1;

  logic              r_last_grant;
  logic              r_inflight;
  logic [DATA_W-1:0] r_fifo [Depth];
  logic [1:0]        r_wptr;
  logic [1:0]        r_rptr;
  logic [2:0]        r_count;

  logic w_rd_elig;
  logic w_gnt_wr;
  logic w_gnt_rd;
  logic w_push;
  logic w_pop;

  // Credit check counts the read still in the memory pipeline so its datum always has a slot.
  assign w_rd_elig = ({1'b0, r_count} + {3'b000, r_inflight}) < 4'd4;

  always_comb begin
    w_gnt_wr = 1'b0;
    w_gnt_rd = 1'b0;
    if (i_wr_valid && i_rd_valid && w_rd_elig) begin
      if (r_last_grant == GntRead) w_gnt_wr = 1'b1;
      else                         w_gnt_rd = 1'b1;
    end else if (i_wr_valid) begin
      w_gnt_wr = 1'b1;
    end else if (i_rd_valid && w_rd_elig) begin
      w_gnt_rd = 1'b1;
    end
  end

  assign o_wr_ready  = i_rst_n & w_gnt_wr;
  assign o_rd_ready  = i_rst_n & w_gnt_rd;
  assign o_mem_wen   = i_wr_valid & o_wr_ready;
  assign o_mem_ren   = i_rd_valid & o_rd_ready;
  assign o_mem_waddr = o_mem_wen ? i_wr_addr : '0;
  assign o_mem_din   = o_mem_wen ? i_wr_data : '0;
  assign o_mem_raddr = o_mem_ren ? i_rd_addr : '0;

  assign w_push      = r_inflight;
  assign o_rsp_valid = (r_count != 3'd0);
  assign w_pop       = o_rsp_valid & i_rsp_ready;
  assign o_rsp_data  = o_rsp_valid ? r_fifo[r_rptr] : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= GntRead;
      r_inflight   <= 1'b0;
      r_wptr       <= 2'd0;
      r_rptr       <= 2'd0;
      r_count      <= 3'd0;
    end else begin
      if (o_mem_wen)      r_last_grant <= GntWrite;
      else if (o_mem_ren) r_last_grant <= GntRead;
      r_inflight <= o_mem_ren;
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: reset clears count, so stale entries are never visible.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_push) r_fifo[r_wptr] <= i_mem_dout;
  end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Self-checking bench for mem_req_scheduler: directed table, hand sequences for
// backpressure/streaming/reset, and randomized traffic against a queue-based model.
module tb_mem_req_scheduler;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid, rd_valid, rsp_ready;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready, rd_ready, rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          mem_wen, mem_ren;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  always #5 clk = ~clk;

  mem_req_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_valid(rd_valid), .o_rd_ready(rd_ready), .i_rd_addr(rd_addr),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_mem_wen(mem_wen), .o_mem_ren(mem_ren), .o_mem_waddr(mem_waddr),
    .o_mem_raddr(mem_raddr), .o_mem_din(mem_din), .i_mem_dout(mem_dout)
  );

  // Memory seen by the DUT: registered read, drives 0 when idle.
  logic [DW-1:0] mem [2048];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr] <= mem_din;
    if (mem_ren) mem_dout <= mem[mem_raddr];
    else         mem_dout <= '0;
  end

  // Reference model: expected memory image, grant history, landed responses, pipeline slot.
  logic [DW-1:0] ref_mem [2048];
  bit            m_last_read;
  bit            m_pipe;
  logic [DW-1:0] m_pipe_data;
  logic [DW-1:0] m_q [$];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit            wv, rv, rr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra;
    bit            e_wr, e_rd, e_v;
    logic [DW-1:0] e_d;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pipe = 1'b0;
    m_last_read = 1'b1;
  endtask

  // One clock: drive at negedge, compare at negedge+1 against the model, advance model at posedge.
  task automatic cycle(input bit wv, input bit rv, input bit rr, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                       output bit a_wr, output bit a_rd, output bit a_v,
                       output logic [DW-1:0] a_d);
    bit e_wr, e_rd, elig;
    logic [DW-1:0] e_d;
    @(negedge clk);
    wr_valid = wv; rd_valid = rv; rsp_ready = rr;
    wr_addr = wa; wr_data = wd; rd_addr = ra;
    #1;
    elig = (m_q.size() + int'(m_pipe)) < 4;
    e_wr = 1'b0; e_rd = 1'b0;
    if (wv && rv && elig) begin
      e_wr = m_last_read;
      e_rd = !m_last_read;
    end else if (wv) e_wr = 1'b1;
    else if (rv && elig) e_rd = 1'b1;
    e_d = (m_q.size() > 0) ? m_q[0] : '0;
    chk("wr_ready", {15'd0, wr_ready}, {15'd0, e_wr});
    chk("rd_ready", {15'd0, rd_ready}, {15'd0, e_rd});
    chk("mem_wen", {15'd0, mem_wen}, {15'd0, e_wr});
    chk("mem_ren", {15'd0, mem_ren}, {15'd0, e_rd});
    chk("mem_waddr", {5'd0, mem_waddr}, e_wr ? {5'd0, wa} : 16'd0);
    chk("mem_din", {8'd0, mem_din}, e_wr ? {8'd0, wd} : 16'd0);
    chk("mem_raddr", {5'd0, mem_raddr}, e_rd ? {5'd0, ra} : 16'd0);
    chk("rsp_valid", {15'd0, rsp_valid}, {15'd0, (m_q.size() > 0)});
    chk("rsp_data", {8'd0, rsp_data}, {8'd0, e_d});
    a_wr = wr_ready; a_rd = rd_ready; a_v = rsp_valid; a_d = rsp_data;
    @(posedge clk);
    if (rr && m_q.size() > 0) void'(m_q.pop_front());
    if (m_pipe) m_q.push_back(m_pipe_data);
    m_pipe = e_rd;
    if (e_rd) m_pipe_data = ref_mem[ra];
    if (e_wr) ref_mem[wa] = wd;
    if (e_wr) m_last_read = 1'b0;
    else if (e_rd) m_last_read = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst rsp_valid", {15'd0, rsp_valid}, 16'd0);
    chk("rst rsp_data", {8'd0, rsp_data}, 16'd0);
    chk("rst wr_ready", {15'd0, wr_ready}, 16'd0);
    chk("rst rd_ready", {15'd0, rd_ready}, 16'd0);
    chk("rst strobes", {14'd0, mem_wen, mem_ren}, 16'd0);
    chk("rst mem_addr", {5'd0, mem_waddr | mem_raddr}, 16'd0);
    model_reset();
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    bit a_wr, a_rd, a_v;
    logic [DW-1:0] a_d;
    logic [DW-1:0] got [$];
    int n_acc;

    for (int i = 0; i < 2048; i++) begin
      mem[i] = DW'(i) ^ 8'hFF;
      ref_mem[i] = DW'(i) ^ 8'hFF;
    end
    wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Write then read same address, then four simultaneous requests (W,R,W,R).
    tbl[0]  = '{1, 0, 1, 11'h5A3, 8'hC7, 11'h000, 1, 0, 0, 8'h00};
    tbl[1]  = '{0, 1, 1, 11'h000, 8'h00, 11'h5A3, 0, 1, 0, 8'h00};
    tbl[2]  = '{0, 0, 1, 11'h000, 8'h00, 11'h000, 0, 0, 0, 8'h00};
    tbl[3]  = '{0, 0, 1, 11'h000, 8'h00, 11'h000, 0, 0, 1, 8'hC7};
    tbl[4]  = '{0, 0, 1, 11'h000, 8'h00, 11'h000, 0, 0, 0, 8'h00};
    tbl[5]  = '{1, 1, 1, 11'h010, 8'h11, 11'h020, 1, 0, 0, 8'h00};
    tbl[6]  = '{1, 1, 1, 11'h011, 8'h22, 11'h020, 0, 1, 0, 8'h00};
    tbl[7]  = '{1, 1, 1, 11'h012, 8'h33, 11'h021, 1, 0, 0, 8'h00};
    tbl[8]  = '{1, 1, 1, 11'h013, 8'h44, 11'h021, 0, 1, 1, 8'hDF};
    tbl[9]  = '{0, 0, 1, 11'h000, 8'h00, 11'h000, 0, 0, 0, 8'h00};
    tbl[10] = '{0, 0, 1, 11'h000, 8'h00, 11'h000, 0, 0, 1, 8'hDE};
    tbl[11] = '{0, 0, 1, 11'h000, 8'h00, 11'h000, 0, 0, 0, 8'h00};
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].wv, tbl[i].rv, tbl[i].rr, tbl[i].wa, tbl[i].wd, tbl[i].ra,
            a_wr, a_rd, a_v, a_d);
      chk($sformatf("tbl%0d wr_ready", i), {15'd0, a_wr}, {15'd0, tbl[i].e_wr});
      chk($sformatf("tbl%0d rd_ready", i), {15'd0, a_rd}, {15'd0, tbl[i].e_rd});
      chk($sformatf("tbl%0d rsp_valid", i), {15'd0, a_v}, {15'd0, tbl[i].e_v});
      chk($sformatf("tbl%0d rsp_data", i), {8'd0, a_d}, {8'd0, tbl[i].e_d});
    end

    // Backpressure: six reads with rsp_ready low, only four accepted.
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(0, 1, 0, '0, '0, AW'(11'h100 + k), a_wr, a_rd, a_v, a_d);
      n_acc += int'(a_rd);
    end
    chk("bp accepted", 16'(n_acc), 16'd4);
    // Writes keep flowing while reads are credit-stalled.
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 0, AW'(11'h200 + k), DW'(8'h50 + k), 11'h104, a_wr, a_rd, a_v, a_d);
      chk("stall wr_ready", {15'd0, a_wr}, 16'd1);
      chk("stall rd_ready", {15'd0, a_rd}, 16'd0);
    end
    got.delete();
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 1, '0, '0, '0, a_wr, a_rd, a_v, a_d);
      if (a_v) got.push_back(a_d);
    end
    chk("bp rsp count", 16'(got.size()), 16'd4);
    for (int k = 0; k < 4 && k < got.size(); k++)
      chk($sformatf("bp rsp%0d", k), {8'd0, got[k]}, {8'd0, 8'hFF - 8'(k)});
    n_acc = 0;
    for (int k = 0; k < 2; k++) begin
      cycle(0, 1, 1, '0, '0, AW'(11'h104 + k), a_wr, a_rd, a_v, a_d);
      n_acc += int'(a_rd);
    end
    chk("bp resume", 16'(n_acc), 16'd2);
    repeat (4) cycle(0, 0, 1, '0, '0, '0, a_wr, a_rd, a_v, a_d);

    // Streaming: 16 reads, one response per cycle in order.
    got.delete();
    for (int k = 0; k < 19; k++) begin
      cycle(0, (k < 16), 1, '0, '0, AW'(k), a_wr, a_rd, a_v, a_d);
      if (k >= 2 && k < 18) chk("stream valid", {15'd0, a_v}, 16'd1);
      if (a_v) got.push_back(a_d);
    end
    chk("stream count", 16'(got.size()), 16'd16);
    for (int k = 0; k < 16 && k < got.size(); k++)
      chk($sformatf("stream rsp%0d", k), {8'd0, got[k]}, {8'd0, 8'(k) ^ 8'hFF});

    // Reset with two entries landed and one read in flight.
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, '0, '0, AW'(11'h300 + k), a_wr, a_rd, a_v, a_d);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 1, '0, '0, '0, a_wr, a_rd, a_v, a_d);
      chk("post-reset stale", {15'd0, a_v}, 16'd0);
    end

    // Randomized traffic over a small address window to exercise write/read hazards.
    for (int k = 0; k < 400; k++) begin
      cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 15)), DW'($urandom),
            AW'($urandom_range(0, 15)), a_wr, a_rd, a_v, a_d);
    end
    repeat (6) cycle(0, 0, 1, '0, '0, '0, a_wr, a_rd, a_v, a_d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_req_scheduler.md
# mem_req_scheduler

Request front end for the 2048 x 8 multi-bank memory. Accepts independent write and read request streams over valid/ready channels and issues at most one operation per cycle, so the memory never sees `ren` and `wen` together. Arbitration between writes and reads is round-robin. Read data is captured into a 4-entry response FIFO and returned over a valid/ready response channel.

## Interface
- `ADDR_W`, 11: address width; must match the memory's `waddr`/`raddr`.
- `DATA_W`, 8: data width; must match the memory's `din`/`dout`.
- `clk` in 1: single clock. All flops update on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `wr_valid` in 1, `wr_ready` out 1, `wr_addr` in ADDR_W, `wr_data` in DATA_W: write request channel.
- `rd_valid` in 1, `rd_ready` out 1, `rd_addr` in ADDR_W: read request channel.
- `rsp_valid` out 1, `rsp_ready` in 1, `rsp_data` out DATA_W: read response channel.
- `mem_wen` out 1, `mem_ren` out 1: memory strobes.
- `mem_waddr` out ADDR_W, `mem_raddr` out ADDR_W, `mem_din` out DATA_W: memory address and data.
- `mem_dout` in DATA_W: memory read data. Valid in the cycle after `mem_ren` was sampled.

## Operation
**State**
- `last_grant`: 1 bit, 0 = WRITE, 1 = READ.
- `inflight`: 1 bit; set when a read was issued in the previous cycle.
- Response FIFO: 4 entries x DATA_W, 2-bit read and write pointers, 3-bit `count`.

**Eligibility**
- Read is eligible when `count + inflight < 4`.
- This credit check guarantees no captured read datum is ever dropped.

**Arbitration** (combinational, evaluated each cycle)
- Both `wr_valid` and `rd_valid` high, read eligible: grant the side opposite `last_grant`.
- Otherwise grant write if `wr_valid`.
- Otherwise grant read if `rd_valid` and eligible.
- Otherwise no grant.
- `wr_ready` = `rst_n` & write granted. `rd_ready` = `rst_n` & read granted. The two are never high together.
- A ready may depend combinationally on the other channel's valid. It never depends on `rsp_ready`.

**Memory drive** (combinational)
- `mem_wen` = `wr_valid & wr_ready`; `mem_waddr` = `wr_addr`; `mem_din` = `wr_data`.
- `mem_ren` = `rd_valid & rd_ready`; `mem_raddr` = `rd_addr`.
- When the corresponding strobe is low, address and data outputs are 0.

**Sequential updates**
- On any grant, `last_grant` takes the granted side; otherwise it holds.
- `inflight` <= `mem_ren`.
- If `inflight` is 1, `mem_dout` is pushed into the FIFO at the edge. `mem_dout` is ignored at all other times; the memory drives 0 when idle.
- Pop when `rsp_valid & rsp_ready`. Simultaneous push and pop leave `count` unchanged. Pointers wrap modulo 4.
- `rsp_valid` = (`count != 0`). `rsp_data` = FIFO head, driven 0 when empty.

## Timing
**Reset values** (while `rst_n` is low)
- `rsp_valid` 0, `rsp_data` 0, `wr_ready` 0, `rd_ready` 0, `mem_wen` 0, `mem_ren` 0, all memory address/data outputs 0.
- `count` 0, pointers 0, `inflight` 0.
- `last_grant` = READ, so the first tie goes to write.

**Latency**
- Write: handshake sampled at edge E; the memory stores at edge E. No response is returned.
- Read: handshake at edge E, memory registers at E, FIFO push at E+1, `rsp_valid` high after E+1.
- Read-to-response latency is therefore 2 edges when the FIFO is empty.

**Throughput**
- One operation per cycle.
- With `rsp_ready` held high, reads sustain one per cycle (`count + inflight` ≤ 2).

**Ordering**
- Responses return in read-issue order.
- A read granted in the cycle after a write to the same address returns the new data.

**Backpressure**
- With `rsp_ready` low, at most 4 reads are accepted: `count` = 4, or `count` = 3 with `inflight` = 1.
- `rd_ready` then stays 0 until a pop occurs. Writes continue unaffected.

**Reset mid-operation**
- An in-flight read and all FIFO contents are discarded.
- No response is produced for them.

## Test plan
1. **Single write then read:** write addr 0x5A3 data 0xC7, next cycle read 0x5A3, `rsp_ready` = 1 -> `rsp_valid` 2 edges after read accept, `rsp_data` = 0xC7; `mem_ren` and `mem_wen` never high together.
2. **Simultaneous requests after reset:** `wr_valid` and `rd_valid` held high for 4 cycles -> grants W, R, W, R; `last_grant` alternates; one op per cycle.
3. **Backpressure:** `rsp_ready` = 0, 6 reads presented back-to-back -> exactly 4 accepted, then `rd_ready` = 0. Raise `rsp_ready` -> 4 responses in order, then remaining reads accepted.
4. **Writes during stall:** reads stalled on credit, `wr_valid` high -> writes granted every cycle despite the pending `rd_valid`.
5. **Streaming:** 16 reads of addresses 0..15 (preloaded data = addr ^ 0xFF), `rsp_ready` = 1 -> one response per cycle, correct order and values.
6. **Async reset mid-stream:** `rst_n` low with `count` = 2 and `inflight` = 1 -> `rsp_valid` drops immediately; after release, no stale response appears.
